trng_sample_packer: RTL and testbench

Parametrised successor to the single-bit clock-enabled sampling flop. It samples NCH raw entropy channels through per-channel synchroniser chains, XOR-combines them into one bit per enabled cycle, and packs the bits into WORD_W-bit words. Each word is offered downstream on a valid/ready handshake, with overflow accounting. It sits between the ring-oscillator entropy sources and the post-processing/readout logic.

---
 rtl/trng_pkg.sv | 19 +
 rtl/trng_bit_sync.sv | 25 ++
 rtl/trng_sample_packer.sv | 129 ++++++++++++
 tb/tb_trng_sample_packer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared defaults, FSM encoding and arithmetic helpers for the TRNG sample packer.
package trng_pkg;

  localparam int NCH_DEF         = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int WORD_W_DEF      = 32;
  localparam int DROP_CNT_W_DEF  = 8;

  typedef enum logic {
    WARM = 1'b0,
    FILL = 1'b1
  } state_t;

  // Increment that sticks at max_val; callers narrow the result to their counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    return (val >= max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/trng_bit_sync.sv
// Clock-enabled synchroniser chain for one raw entropy bit.
// Latency is STAGES enabled edges; the chain holds whenever ce is low.
module trng_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic ce,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= '0;
    end else if (ce) begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/trng_sample_packer.sv
// Samples NCH entropy channels, XORs them and packs bits MSB-first into WORD_W-bit words.
// First word after SYNC_STAGES+WORD_W enabled edges; a word completing while the output is stalled is dropped and counted.
module trng_sample_packer
  import trng_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int DROP_CNT_W  = DROP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  ce,
  input  logic [NCH-1:0]        d_in,
  output logic [WORD_W-1:0]     word_out,
  output logic                  valid,
  input  logic                  ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  busy
);

  localparam int BIT_CNT_W  = $clog2(WORD_W);
  localparam int WARM_CNT_W = $clog2(SYNC_STAGES);

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
  localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(SYNC_STAGES - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;

  logic [NCH-1:0]        sync_q;
  logic                  comb_bit;

  state_t                state_q, state_d;
  logic [WARM_CNT_W-1:0] warm_cnt_q, warm_cnt_d;

  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [WORD_W-1:0]     shift_q;
  logic [WORD_W-1:0]     word_q;
  logic                  valid_q;
  logic [DROP_CNT_W-1:0] drop_q;

  logic                  fill_en;
  logic                  word_done;
  logic                  can_load;
  logic [WORD_W-1:0]     next_word;
  logic [DROP_CNT_W-1:0] drop_next;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_sync
    trng_bit_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .clr_n (clr_n),
      .ce    (ce),
      .d     (d_in[ch]),
      .q     (sync_q[ch])
    );
  end

  assign comb_bit = ^sync_q;

  // Warm-up discards the edges that only flush reset zeros out of the chains.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= WARM;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      WARM: begin
        if (ce) begin
          if (warm_cnt_q == WARM_LAST) begin
            state_d    = FILL;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        state_d = FILL;
      end
    endcase
  end

  assign fill_en   = ce && (state_q == FILL);
  assign word_done = fill_en && (bit_cnt_q == LAST_BIT);
  assign next_word = {shift_q[WORD_W-2:0], comb_bit};
  assign can_load  = !valid_q || ready;
  assign drop_next = DROP_CNT_W'(sat_inc(64'(drop_q), 64'(DROP_MAX)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (fill_en) begin
      shift_q   <= next_word;
      bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // Output side is not gated by ce so a pending word can drain while sampling is paused.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else if (word_done && can_load) begin
      word_q  <= next_word;
      valid_q <= 1'b1;
    end else if (word_done) begin
      drop_q  <= drop_next;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  assign word_out = word_q;
  assign valid    = valid_q;
  assign drop_cnt = drop_q;
  assign busy     = (state_q == WARM);

endmodule

// File: tb/tb_trng_sample_packer.sv
// Directed and randomized checks of trng_sample_packer against a queue-based reference model.
module tb_trng_sample_packer;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int W   = 8;
  localparam int DW  = 2;

  logic           clk = 1'b0;
  logic           clr_n;
  logic           ce;
  logic [NCH-1:0] d_in;
  logic           ready;
  logic [W-1:0]   word_out;
  logic           valid;
  logic [DW-1:0]  drop_cnt;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // Reference model: delay line of combined samples, list of packed bits, output slot.
  bit           hist[$];
  bit           mbits[$];
  logic [W-1:0] m_word;
  logic         m_valid;
  int           m_drop;
  bit           m_done;
  logic [W-1:0] m_last;

  trng_sample_packer #(
    .NCH(NCH), .SYNC_STAGES(SS), .WORD_W(W), .DROP_CNT_W(DW)
  ) dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .d_in(d_in),
    .word_out(word_out), .valid(valid), .ready(ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    mbits.delete();
    m_word  = '0;
    m_valid = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_edge(input logic c, input logic [NCH-1:0] d, input logic r);
    bit b;
    bit have;
    have   = 1'b0;
    b      = 1'b0;
    m_done = 1'b0;
    if (c) begin
      if (hist.size() == SS) begin
        b    = hist.pop_front();
        have = 1'b1;
      end
      hist.push_back(^d);
      if (have) begin
        mbits.push_back(b);
        if (mbits.size() == W) begin
          for (int i = 0; i < W; i++) m_last[W-1-i] = mbits[i];
          mbits.delete();
          m_done = 1'b1;
        end
      end
    end
    if (m_done) begin
      if (!m_valid || r) begin
        m_word  = m_last;
        m_valid = 1'b1;
      end else if (m_drop < (1 << DW) - 1) begin
        m_drop++;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_check(input string tag);
    cmp({tag, "_valid"}, 32'(valid), 32'(m_valid));
    cmp({tag, "_word"},  32'(word_out), 32'(m_word));
    cmp({tag, "_drop"},  32'(drop_cnt), m_drop);
    cmp({tag, "_busy"},  32'(busy), 32'(hist.size() < SS));
  endtask

  task automatic step(input logic c, input logic [NCH-1:0] d, input logic r);
    ce    = c;
    d_in  = d;
    ready = r;
    @(posedge clk);
    model_edge(c, d, r);
    #1;
    model_check("step");
  endtask

  task automatic do_reset();
    #2 clr_n = 1'b0;
    model_reset();
    #1;
    model_check("rst");
    @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    logic [15:0]    pat;
    logic [W-1:0]   held;
    logic [NCH-1:0] dv;

    clr_n = 1'b1;
    ce    = 1'b0;
    d_in  = '0;
    ready = 1'b0;
    model_reset();

    // 1: constant single-channel ones fill an all-ones word
    do_reset();
    cmp("t1_reset_valid", 32'(valid), 32'd0);
    cmp("t1_reset_busy",  32'(busy),  32'd1);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 4'b0001, 1'b1);
      if (i == 2) cmp("t1_busy_e2", 32'(busy), 32'd0);
      if (i == 9) cmp("t1_valid_e9", 32'(valid), 32'd0);
    end
    cmp("t1_valid_e10", 32'(valid), 32'd1);
    cmp("t1_word_ff", 32'(word_out), 32'hFF);

    // 2: known bit patterns, MSB first
    do_reset();
    pat = 16'hA53C;
    for (int i = 0; i < 18; i++) begin
      dv = (i < 16) ? {3'b000, pat[15-i]} : 4'b0000;
      step(1'b1, dv, 1'b1);
      if (i == 9)  cmp("t2_word_a5", 32'(word_out), 32'hA5);
      if (i == 17) cmp("t2_word_3c", 32'(word_out), 32'h3C);
    end

    // 3: backpressure holds the first word and counts drops
    do_reset();
    held = '0;
    for (int i = 1; i <= 26; i++) begin
      step(1'b1, 4'($urandom), 1'b0);
      if (i == 10) held = m_word;
    end
    cmp("t3_valid", 32'(valid), 32'd1);
    cmp("t3_hold", 32'(word_out), 32'(held));
    cmp("t3_drop2", 32'(drop_cnt), 32'd2);
    step(1'b1, 4'($urandom), 1'b1);
    cmp("t3_valid_after_pulse", 32'(valid), 32'd0);
    for (int i = 28; i <= 34; i++) begin
      step(1'b1, 4'($urandom), 1'b0);
      if (i == 33) cmp("t3_valid_e33", 32'(valid), 32'd0);
    end
    cmp("t3_valid_e34", 32'(valid), 32'd1);

    // 4: saturation, then ready on a completion edge
    for (int i = 0; i < 16; i++) step(1'b1, 4'($urandom), 1'b0);
    cmp("t4_drop_sat", 32'(drop_cnt), 32'd3);
    for (int i = 0; i < W - 1; i++) step(1'b1, 4'($urandom), 1'b0);
    step(1'b1, 4'($urandom), 1'b1);
    cmp("t4_valid_kept", 32'(valid), 32'd1);
    cmp("t4_new_word", 32'(word_out), 32'(m_last));
    cmp("t4_drop_same", 32'(drop_cnt), 32'd3);

    // 5: ce gating keeps the partial word and still drains
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 4'($urandom), 1'b0);
    step(1'b0, 4'($urandom), 1'b1);
    cmp("t5_drain_ce0", 32'(valid), 32'd0);
    for (int i = 0; i < 19; i++) step(1'b0, 4'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom), 1'b0);
    cmp("t5_valid", 32'(valid), 32'd1);
    cmp("t5_word", 32'(word_out), 32'(m_last));

    // 6: async reset mid-word, then full warm-up again
    do_reset();
    for (int i = 0; i < 31; i++) step(1'b1, 4'($urandom), 1'b0);
    cmp("t6_pre_valid", 32'(valid), 32'd1);
    cmp("t6_pre_drop", 32'(drop_cnt), 32'd2);
    #2 clr_n = 1'b0;
    model_reset();
    #1;
    cmp("t6_rst_valid", 32'(valid), 32'd0);
    cmp("t6_rst_word", 32'(word_out), 32'd0);
    cmp("t6_rst_drop", 32'(drop_cnt), 32'd0);
    cmp("t6_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 clr_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 4'($urandom), 1'b1);
      if (i == 9) cmp("t6_valid_e9", 32'(valid), 32'd0);
    end
    cmp("t6_valid_e10", 32'(valid), 32'd1);

    // Random soak against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 9) < 7), 4'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
